// File: rtl/mmio_sw_port.sv
// Load-side MMIO port: synchronized, debounced switches with an event FIFO.
// Define SWPORT_IRQ_EN to enable the registered irq output and CTRL irq_en bit.
`timescale 1ns/1ps
module mmio_sw_port #(
  parameter int              CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int              FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]      s1, s2, cand, sw_db;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             irq_en_v;

  logic [1:0]  sel;
  logic        not_empty, full, commit, pop;
  logic        ctrl_wr, flush, clr_ovf, do_push, drop;
  logic [31:0] ev;
  logic [4:0]  count5;

  assign sel       = addr[3:2];
  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign commit    = (s2 == cand) && (cnt == DEBOUNCE_CYCLES)
                     && (cand != sw_db);
  assign ev        = {sw_db ^ cand, cand};
  assign pop       = cs && !we && (sel == 2'd2) && not_empty;
  assign ctrl_wr   = cs && we && (sel == 2'd3);
  assign flush     = ctrl_wr && wdata[1];
  assign clr_ovf   = ctrl_wr && wdata[0];
  // A pop frees the slot this cycle, so a full FIFO still accepts the push.
  assign do_push   = commit && (!full || pop) && !flush;
  assign drop      = commit && full && !pop && !flush;
  assign count5    = 5'(count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      sw_db <= '0;
      cnt   <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != DEBOUNCE_CYCLES) begin
        cnt <= cnt + 1'b1;
      end else if (cand != sw_db) begin
        sw_db <= cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (do_push) wp <= wp + 1'b1;
        if (pop)     rp <= rp + 1'b1;
        if (do_push && !pop)
          count <= count + CW'(1);
        else if (pop && !do_push)
          count <= count - CW'(1);
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

`ifdef SWPORT_IRQ_EN
  logic irq_en, irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wdata[2];
      irq_q <= irq_en && not_empty;
    end
  end

  assign irq_en_v = irq_en;
  assign irq      = irq_q;
`else
  assign irq_en_v = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (sel)
        2'd0: rdata = {16'b0, sw_db};
        2'd1: rdata = {23'b0, count5, 1'b0, overflow, full, not_empty};
        2'd2: rdata = not_empty ? mem[rp] : 32'b0;
        default: rdata = {29'b0, irq_en_v, 2'b0};
      endcase
    end
  end

  logic unused;
  assign unused = ^{wdata[31:3], wdata[2], addr[1:0]};
endmodule

// File: tb/tb_mmio_sw_port.sv
// Scoreboard bench for mmio_sw_port (DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4).
// Expected values are queued by stimulus and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_mmio_sw_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] sw_in = 16'h0;
  logic        irq;

`ifdef SWPORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  localparam logic [3:0] DATA = 4'h0, STAT = 4'h4;
  localparam logic [3:0] EVNT = 4'h8, CTRL = 4'hC;

  mmio_sw_port #(
    .CNT_W(16),
    .DEBOUNCE_CYCLES(16'd4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .sw_in(sw_in),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int          vecs = 0;
  int          bad = 0;
  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  int          m_k;
  logic [31:0] m_e, m_a;
  string       m_n;

  // Monitor: kind 0 checks rdata, kind 1 checks irq.
  always @(negedge clk) begin
    while (q_kind.size() > 0) begin
      m_k = q_kind.pop_front();
      m_e = q_exp.pop_front();
      m_n = q_name.pop_front();
      m_a = (m_k == 0) ? rdata : {31'b0, irq};
      vecs++;
      if (m_a !== m_e) begin
        bad++;
        $display("FAIL %s: got %h want %h", m_n, m_a, m_e);
      end
    end
  end

  task automatic expect_v(input int k, input logic [31:0] e,
                          input string n);
    q_kind.push_back(k);
    q_exp.push_back(e);
    q_name.push_back(n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e,
                    input string n);
    cs = 1'b1;
    we = 1'b0;
    addr = a;
    expect_v(0, e, n);
    cyc();
    cs = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1;
    we = 1'b1;
    addr = a;
    wdata = d;
    cyc();
    cs = 1'b0;
    we = 1'b0;
    wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw_in = '0;
    cs = 1'b0;
    we = 1'b0;
    repeat (2) cyc();
    expect_v(0, 32'h0, "rst_rdata");
    expect_v(1, 32'h0, "rst_irq");
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic settle(input logic [15:0] v);
    sw_in = v;
    repeat (10) cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    do_reset();
    rd(DATA, 32'h0, "reset_data");
    rd(STAT, 32'h0, "reset_status");
    expect_v(1, 32'h0, "reset_irq");
    expect_v(0, 32'h0, "cs_low_rdata");
    cyc();

    // Clean step: commit on the 8th edge after the change.
    sw_in = 16'h00A5;
    repeat (7) cyc();
    rd(DATA, 32'h0, "pre_commit_data");
    rd(DATA, 32'h0000_00A5, "commit_data");
    rd(STAT, 32'h11, "commit_status");
    rd(EVNT, 32'h00A5_00A5, "first_event");
    rd(STAT, 32'h0, "after_pop_status");
    rd(EVNT, 32'h0, "empty_event");

    // Bounce: 3-cycle pulses never reach the debounce count.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sw_in = (i % 2 == 0) ? 16'h1 : 16'h0;
      rd(STAT, 32'h0, "bounce_status");
      repeat (2) cyc();
    end
    sw_in = 16'h1;
    repeat (10) cyc();
    rd(STAT, 32'h11, "bounce_one_event");
    rd(EVNT, 32'h0001_0001, "bounce_event");
    rd(STAT, 32'h0, "bounce_drained");

    // Overflow: five commits into a 4-deep FIFO.
    do_reset();
    for (int v = 1; v <= 5; v++) settle(16'(v));
    rd(STAT, 32'h47, "ovf_status");
    rd(EVNT, 32'h0001_0001, "ovf_ev0");
    rd(EVNT, 32'h0003_0002, "ovf_ev1");
    rd(EVNT, 32'h0001_0003, "ovf_ev2");
    rd(EVNT, 32'h0007_0004, "ovf_ev3");
    rd(EVNT, 32'h0, "ovf_ev_empty");
    rd(STAT, 32'h04, "ovf_sticky");
    wr(CTRL, 32'h1);
    rd(STAT, 32'h0, "ovf_cleared");

    // Full FIFO: pop and push on the same edge.
    do_reset();
    for (int v = 1; v <= 4; v++) settle(16'(v));
    rd(STAT, 32'h43, "full_status");
    sw_in = 16'h5;
    repeat (7) cyc();
    rd(EVNT, 32'h0001_0001, "full_pop_push");
    rd(STAT, 32'h43, "full_still");
    rd(EVNT, 32'h0003_0002, "fp_ev1");
    rd(EVNT, 32'h0001_0003, "fp_ev2");
    rd(EVNT, 32'h0007_0004, "fp_ev3");
    rd(EVNT, 32'h0001_0005, "fp_ev4");
    rd(STAT, 32'h0, "fp_drained");

    // Flush on the commit edge discards the push and pending events.
    settle(16'h7);
    rd(STAT, 32'h11, "pre_flush_status");
    sw_in = 16'h6;
    repeat (7) cyc();
    wr(CTRL, 32'h2);
    rd(STAT, 32'h0, "flush_status");
    rd(DATA, 32'h6, "flush_data");
    repeat (8) cyc();
    rd(STAT, 32'h0, "flush_no_late_push");

    // Interrupt: rises one cycle after not_empty, falls one after pop.
    do_reset();
    wr(CTRL, 32'h4);
    rd(CTRL, IRQ ? 32'h4 : 32'h0, "ctrl_read");
    sw_in = 16'h1;
    repeat (7) cyc();
    expect_v(1, 32'h0, "irq_pre");
    rd(STAT, 32'h0, "irq_pre_status");
    expect_v(1, 32'h0, "irq_lag");
    rd(STAT, 32'h11, "irq_ne_status");
    expect_v(1, {31'b0, IRQ}, "irq_high");
    rd(EVNT, 32'h0001_0001, "irq_event");
    expect_v(1, {31'b0, IRQ}, "irq_hold");
    rd(STAT, 32'h0, "irq_popped");
    expect_v(1, 32'h0, "irq_low");
    rd(STAT, 32'h0, "irq_end_status");

    cyc();
    cyc();
    if (q_kind.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0",
               q_kind.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
